// File: rtl/prng_pkg.sv
// Shared types and constants for the burst-mode PRNG controller.
package prng_pkg;

  localparam int unsigned CSR_W         = 3;
  localparam int unsigned STEP_W        = 8;
  localparam int unsigned DEFAULT_WIDTH = 128;

  localparam logic [CSR_W-1:0] STAT_IDLE     = 3'd0;
  localparam logic [CSR_W-1:0] STAT_DONE     = 3'd1;
  localparam logic [CSR_W-1:0] STAT_BUSY     = 3'd2;
  localparam logic [CSR_W-1:0] STAT_SEED_ERR = 3'd4;

  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_TAPS = 128'hE1 << 120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_EMIT,
    ST_DONE
  } prngState_t;

  // Completion code, flagging a substituted zero seed.
  function automatic logic [CSR_W-1:0] doneStatus(input logic seedErr);
    return seedErr ? (STAT_DONE | STAT_SEED_ERR) : STAT_DONE;
  endfunction

endpackage

// File: rtl/prng_burst_ctrl_lfsr_core.sv
// Galois LFSR with seed load; an all-zero seed is replaced by 1 so the
// sequence can never lock up.
module lfsr_core
  import prng_pkg::*;
#(
  parameter int unsigned       WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(DEFAULT_TAPS)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  output logic [WIDTH-1:0] state_o,
  output logic             zero_seed
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] lfsrState;
  logic [WIDTH-1:0] lfsrNext;

  assign lfsrNext  = (lfsrState >> 1) ^ (lfsrState[0] ? TAPS : '0);
  assign zero_seed = load && (load_val == '0);
  assign state_o   = lfsrState;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lfsrState <= ONE;
    end else if (load) begin
      lfsrState <= zero_seed ? ONE : load_val;
    end else if (shift) begin
      lfsrState <= lfsrNext;
    end
  end

endmodule

// File: rtl/prng_burst_ctrl.sv
// Burst PRNG controller: seeds an LFSR on start, then streams a programmed
// number of words over valid/ready with CSR status strobes.
module prng_burst_ctrl
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH          = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS           = WIDTH'(DEFAULT_TAPS),
  parameter int unsigned      STEPS_PER_WORD = 128,
  parameter int unsigned      LEN_W          = 5
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_seed,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] burst_len,
  output logic [WIDTH-1:0] data_o,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CSR_W-1:0] csr_o,
  output logic             csr_update,
  output logic             busy
);

  localparam logic [STEP_W-1:0] STEPS_LAST = STEP_W'(STEPS_PER_WORD);
  localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

  prngState_t       state, stateNext;
  logic [WIDTH-1:0] seedReg;
  logic             loadSeedReg;
  logic [LEN_W-1:0] lenReg;
  logic [LEN_W-1:0] wordCnt;
  logic [STEP_W-1:0] stepCnt;
  logic             seedErr;

  logic [WIDTH-1:0] lfsrState;
  logic             zeroSeed;

  logic             latchCmd;
  logic             lfsrLoad;
  logic             lfsrShift;
  logic             capture;
  logic             clrCnt;
  logic             clrStep;
  logic             stepInc;
  logic             wordInc;
  logic             strobe;
  logic [CSR_W-1:0] csrNext;
  logic             transfer;

  assign transfer = data_valid && data_ready;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clock     (clock),
    .rst_n     (rst_n),
    .load      (lfsrLoad),
    .load_val  (seedReg),
    .shift     (lfsrShift),
    .state_o   (lfsrState),
    .zero_seed (zeroSeed)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Strobes are registered, so each one is raised on the edge entering the
  // state it reports; abort outranks everything including a same-cycle transfer.
  always_comb begin
    stateNext = state;
    latchCmd  = 1'b0;
    lfsrLoad  = 1'b0;
    lfsrShift = 1'b0;
    capture   = 1'b0;
    clrCnt    = 1'b0;
    clrStep   = 1'b0;
    stepInc   = 1'b0;
    wordInc   = 1'b0;
    strobe    = 1'b0;
    csrNext   = STAT_IDLE;
    if (state != ST_IDLE && abort) begin
      stateNext = ST_IDLE;
      strobe    = 1'b1;
      csrNext   = STAT_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            stateNext = ST_LOAD;
            latchCmd  = 1'b1;
            strobe    = 1'b1;
            csrNext   = STAT_BUSY;
          end
        end
        ST_LOAD: begin
          lfsrLoad  = loadSeedReg;
          clrCnt    = 1'b1;
          stateNext = ST_RUN;
        end
        ST_RUN: begin
          lfsrShift = 1'b1;
          stepInc   = 1'b1;
          if (STEP_W'(stepCnt + 8'd1) == STEPS_LAST) begin
            capture   = 1'b1;
            stateNext = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (transfer) begin
            wordInc = 1'b1;
            if (LEN_W'(wordCnt + LEN_ONE) == lenReg) begin
              stateNext = ST_DONE;
              strobe    = 1'b1;
              csrNext   = doneStatus(seedErr);
            end else begin
              clrStep   = 1'b1;
              stateNext = ST_RUN;
            end
          end
        end
        ST_DONE: stateNext = ST_IDLE;
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  // Command capture, counters, sticky seed error and registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      seedReg     <= '0;
      loadSeedReg <= 1'b0;
      lenReg      <= '0;
      wordCnt     <= '0;
      stepCnt     <= '0;
      seedErr     <= 1'b0;
      data_o      <= '0;
      data_valid  <= 1'b0;
      csr_o       <= STAT_IDLE;
      csr_update  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (latchCmd) begin
        seedReg     <= seed;
        loadSeedReg <= load_seed;
        lenReg      <= (burst_len == '0) ? LEN_ONE : burst_len;
        seedErr     <= 1'b0;
      end
      if (zeroSeed) seedErr <= 1'b1;

      if (clrCnt) begin
        wordCnt <= '0;
        stepCnt <= '0;
      end else begin
        if (clrStep)      stepCnt <= '0;
        else if (stepInc) stepCnt <= STEP_W'(stepCnt + 8'd1);
        if (wordInc)      wordCnt <= LEN_W'(wordCnt + LEN_ONE);
      end

      if (capture) data_o <= (lfsrState >> 1) ^ (lfsrState[0] ? TAPS : '0);

      data_valid <= (stateNext == ST_EMIT);
      busy       <= (stateNext != ST_IDLE);
      csr_update <= strobe;
      if (strobe) csr_o <= csrNext;
    end
  end

endmodule

// File: tb/tb_prng_burst_ctrl.sv
// Directed bench for prng_burst_ctrl with WIDTH=16, TAPS=16'hB400, one step per word.
module tb_prng_burst_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned L = 5;

  logic         clock = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         load_seed = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] seed = '0;
  logic [L-1:0] burst_len = '0;
  logic [W-1:0] data_o;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic [2:0]   csr_o;
  logic         csr_update;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] wordQ[$];
  logic [2:0]   strobeQ[$];

  always #5 clock = ~clock;

  prng_burst_ctrl #(
    .WIDTH          (W),
    .TAPS           (16'hB400),
    .STEPS_PER_WORD (1),
    .LEN_W          (L)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .load_seed  (load_seed),
    .abort      (abort),
    .seed       (seed),
    .burst_len  (burst_len),
    .data_o     (data_o),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .csr_o      (csr_o),
    .csr_update (csr_update),
    .busy       (busy)
  );

  // Record words offered with ready high and every CSR strobe.
  always @(negedge clock) begin
    if (rst_n && data_valid && data_ready) wordQ.push_back(data_o);
    if (rst_n && csr_update) strobeQ.push_back(csr_o);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doStart(input logic [W-1:0] s, input logic ld, input logic [L-1:0] len);
    wordQ.delete();
    strobeQ.delete();
    seed = s; load_seed = ld; burst_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles, output logic timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < maxCycles; i++) begin
      tick();
      if (!busy) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic waitSecondWord(input int maxCycles, output logic timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < maxCycles; i++) begin
      tick();
      if (data_valid && wordQ.size() == 1) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({data_o, data_valid, csr_o, csr_update, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got dv=%b csr=%0d upd=%b busy=%b data=%h required all zero",
               data_valid, csr_o, csr_update, busy, data_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic to;
    logic [W-1:0] exp[3];
    exp[0] = 16'hB400; exp[1] = 16'h5A00; exp[2] = 16'h2D00;
    data_ready = 1'b1;
    doStart(16'h0001, 1'b1, 5'd3);
    checks++;
    if (!(busy === 1'b1 && csr_update === 1'b1 && csr_o === 3'd2)) begin
      errors++;
      $display("FAIL basic_load_strobe: got busy=%b upd=%b csr=%0d required 1 1 2", busy, csr_update, csr_o);
    end
    tick();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %b required 0", data_valid);
    end
    tick();
    checks++;
    if (!(data_valid === 1'b1 && data_o === 16'hB400)) begin
      errors++;
      $display("FAIL basic_first_latency: got dv=%b data=%h required 1 b400", data_valid, data_o);
    end
    waitIdle(50, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL basic_timeout: got busy=%b required 0", busy);
    end
    checks++;
    if (wordQ.size() !== 3) begin
      errors++;
      $display("FAIL basic_count: got %0d required 3", wordQ.size());
    end
    for (int i = 0; i < 3 && i < wordQ.size(); i++) begin
      checks++;
      if (wordQ[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got %h required %h", i, wordQ[i], exp[i]);
      end
    end
    checks++;
    if (!(strobeQ.size() == 2 && strobeQ[0] === 3'd2 && strobeQ[1] === 3'd1)) begin
      errors++;
      $display("FAIL basic_strobes: got %0d strobes required 2 then 1", strobeQ.size());
    end
  endtask

  task automatic test_continue();
    logic to;
    doStart(16'hFFFF, 1'b0, 5'd1);
    waitIdle(50, to);
    checks++;
    if (!(to === 1'b0 && wordQ.size() == 1 && wordQ[0] === 16'h1680)) begin
      errors++;
      $display("FAIL continue_word: got n=%0d first=%h required 1 word 1680", wordQ.size(),
               (wordQ.size() > 0) ? wordQ[0] : 16'h0);
    end
  endtask

  task automatic test_back_pressure();
    logic to;
    data_ready = 1'b1;
    doStart(16'h0001, 1'b1, 5'd3);
    waitSecondWord(50, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL bp_timeout: got no second word required one");
    end
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (!(data_valid === 1'b1 && data_o === 16'h5A00)) begin
        errors++;
        $display("FAIL bp_hold%0d: got dv=%b data=%h required 1 5a00", i, data_valid, data_o);
      end
    end
    data_ready = 1'b1;
    waitIdle(50, to);
    checks++;
    if (!(to === 1'b0 && wordQ.size() == 3 && wordQ[1] === 16'h5A00 && wordQ[2] === 16'h2D00)) begin
      errors++;
      $display("FAIL bp_sequence: got n=%0d required 3 words b400 5a00 2d00", wordQ.size());
    end
  endtask

  task automatic test_zero_seed();
    logic to;
    doStart(16'h0000, 1'b1, 5'd1);
    waitIdle(50, to);
    checks++;
    if (!(to === 1'b0 && wordQ.size() == 1 && wordQ[0] === 16'hB400)) begin
      errors++;
      $display("FAIL zero_seed_word: got n=%0d required 1 word b400", wordQ.size());
    end
    checks++;
    if (!(strobeQ.size() == 2 && strobeQ[1] === 3'd5)) begin
      errors++;
      $display("FAIL zero_seed_status: got %0d (n=%0d) required 5",
               (strobeQ.size() > 1) ? strobeQ[1] : 3'd0, strobeQ.size());
    end
  endtask

  task automatic test_abort();
    logic to;
    data_ready = 1'b1;
    doStart(16'h0001, 1'b1, 5'd4);
    waitSecondWord(50, to);
    checks++;
    if (to !== 1'b0) begin
      errors++;
      $display("FAIL abort_timeout: got no second word required one");
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (!(data_valid === 1'b0 && csr_update === 1'b1 && csr_o === 3'd0 && busy === 1'b0)) begin
      errors++;
      $display("FAIL abort_response: got dv=%b upd=%b csr=%0d busy=%b required 0 1 0 0",
               data_valid, csr_update, csr_o, busy);
    end
    wordQ.delete();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (wordQ.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d words busy=%b required 0 0", wordQ.size(), busy);
    end
    doStart(16'h0000, 1'b0, 5'd1);
    waitIdle(50, to);
    checks++;
    if (!(to === 1'b0 && wordQ.size() == 1 && wordQ[0] === 16'h2D00)) begin
      errors++;
      $display("FAIL abort_resume: got n=%0d required 1 word 2d00", wordQ.size());
    end
    checks++;
    if (!(strobeQ.size() == 2 && strobeQ[1] === 3'd1)) begin
      errors++;
      $display("FAIL abort_resume_status: got n=%0d required final status 1", strobeQ.size());
    end
  endtask

  task automatic test_reset_mid();
    logic to;
    doStart(16'h0001, 1'b1, 5'd2);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_o, data_valid, csr_o, csr_update, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got dv=%b csr=%0d upd=%b busy=%b data=%h required all zero",
               data_valid, csr_o, csr_update, busy, data_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    doStart(16'h0000, 1'b0, 5'd1);
    waitIdle(50, to);
    checks++;
    if (!(to === 1'b0 && wordQ.size() == 1 && wordQ[0] === 16'hB400)) begin
      errors++;
      $display("FAIL reset_lfsr: got n=%0d required 1 word b400", wordQ.size());
    end
  endtask

  task automatic test_len_edges();
    logic to;
    data_ready = 1'b1;
    doStart(16'h0001, 1'b1, 5'd0);
    waitIdle(50, to);
    checks++;
    if (!(to === 1'b0 && wordQ.size() == 1 && wordQ[0] === 16'hB400)) begin
      errors++;
      $display("FAIL len0: got n=%0d required 1 word b400", wordQ.size());
    end
    doStart(16'h0000, 1'b0, 5'd31);
    waitIdle(300, to);
    checks++;
    if (!(to === 1'b0 && wordQ.size() == 31 && wordQ[0] === 16'h5A00)) begin
      errors++;
      $display("FAIL len31: got n=%0d timeout=%b required 31 words starting 5a00", wordQ.size(), to);
    end
    checks++;
    if (!(strobeQ.size() == 2 && strobeQ[1] === 3'd1)) begin
      errors++;
      $display("FAIL len31_status: got n=%0d required final status 1", strobeQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continue();
    test_back_pressure();
    test_zero_seed();
    test_abort();
    test_reset_mid();
    test_len_edges();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
